// File: rtl/jelly_fixed_reciprocal_arbiter.sv
// jelly_fixed_reciprocal_arbiter
// Shares one valid/ready fixed-point reciprocal pipeline between NUM requesters.
// Requests are granted round-robin into a one-entry issue register with the
// requester index carried in the user tag. Returned results are steered back
// into per-port one-deep response registers. A credit counter caps the number
// of operations in flight, so one stalled response port cannot wedge the pipe.
// Optional: define JELLY_FIXED_RECIPROCAL_ARBITER_STATUS_EN to add the
// status_credit / status_grant observation outputs.
module jelly_fixed_reciprocal_arbiter #(
  parameter int NUM             = 4,
  parameter int ID_WIDTH        = 2,
  parameter int S_FIXED_WIDTH   = 32,
  parameter int M_FIXED_WIDTH   = 32,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         cke,

  input  logic [NUM*S_FIXED_WIDTH-1:0] s_req_fixed,
  input  logic [NUM-1:0]               s_req_valid,
  output logic [NUM-1:0]               s_req_ready,

  output logic [NUM*M_FIXED_WIDTH-1:0] m_rsp_fixed,
  output logic [NUM-1:0]               m_rsp_valid,
  input  logic [NUM-1:0]               m_rsp_ready,

  output logic [ID_WIDTH-1:0]          m_user,
  output logic [S_FIXED_WIDTH-1:0]     m_fixed,
  output logic                         m_valid,
  input  logic                         m_ready,

  input  logic [ID_WIDTH-1:0]          s_user,
  input  logic [M_FIXED_WIDTH-1:0]     s_fixed,
  input  logic                         s_valid,
  output logic                         s_ready
`ifdef JELLY_FIXED_RECIPROCAL_ARBITER_STATUS_EN
  ,
  output logic [7:0]                   status_credit,
  output logic [NUM-1:0]               status_grant
`endif
);

  localparam int         PTR_W      = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [7:0] CREDIT_MAX = 8'(MAX_OUTSTANDING);

  // Architectural state
  logic [PTR_W-1:0]         rr_q, rr_d;
  logic [7:0]               credit_q, credit_d;
  logic                     m_valid_q, m_valid_d;
  logic [ID_WIDTH-1:0]      m_user_q, m_user_d;
  logic [S_FIXED_WIDTH-1:0] m_fixed_q, m_fixed_d;

  // Arbitration / return steering
  logic                     issue_open;
  logic                     grant_found;
  logic                     grant;
  logic [PTR_W-1:0]         grant_idx;
  logic [PTR_W:0]           scan_idx;
  logic [S_FIXED_WIDTH-1:0] grant_fixed;
  logic                     ret_busy;
  logic                     ret_accept;
  logic [NUM-1:0]           ret_load;

  // The issue register may take a new operand when it is empty or draining,
  // but only while credit remains; a same-cycle return never bypasses the cap.
  assign issue_open = cke & reset_n & (~m_valid_q | m_ready) & (credit_q < CREDIT_MAX);
  assign grant      = issue_open & grant_found;

  // Round-robin search: first valid port at or after the pointer, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM; k++) begin
      scan_idx = {1'b0, rr_q} + (PTR_W+1)'(k);
      if (scan_idx >= (PTR_W+1)'(NUM)) begin
        scan_idx = scan_idx - (PTR_W+1)'(NUM);
      end
      if (!grant_found && s_req_valid[scan_idx[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[PTR_W-1:0];
      end
    end
  end

  // Operand mux and one-hot ready toward the granted requester only.
  always_comb begin
    grant_fixed = '0;
    s_req_ready = '0;
    for (int i = 0; i < NUM; i++) begin
      if (grant_idx == PTR_W'(i)) begin
        grant_fixed    = s_req_fixed[i*S_FIXED_WIDTH +: S_FIXED_WIDTH];
        s_req_ready[i] = grant;
      end
    end
  end

  // Return steering: blocked only if the tagged port's slot is full and not
  // draining. Out-of-range tags match no port, so they are accepted and dropped.
  always_comb begin
    ret_busy = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      if (s_user == ID_WIDTH'(i)) begin
        ret_busy = m_rsp_valid[i] & ~m_rsp_ready[i];
      end
    end
  end

  assign s_ready    = cke & reset_n & ~ret_busy;
  assign ret_accept = s_valid & s_ready;

  // One-hot load strobe for the response slot addressed by the returned tag.
  always_comb begin
    ret_load = '0;
    for (int i = 0; i < NUM; i++) begin
      ret_load[i] = ret_accept & (s_user == ID_WIDTH'(i));
    end
  end

  // Credit: +1 per grant, -1 per accepted return, never below zero.
  always_comb begin
    credit_d = credit_q;
    if (grant && !ret_accept) begin
      credit_d = credit_q + 8'd1;
    end else if (!grant && ret_accept && (credit_q != 8'd0)) begin
      credit_d = credit_q - 8'd1;
    end
  end

  // Issue register next state and round-robin pointer advance.
  always_comb begin
    m_valid_d = m_valid_q;
    m_user_d  = m_user_q;
    m_fixed_d = m_fixed_q;
    rr_d      = rr_q;
    if (grant) begin
      m_valid_d = 1'b1;
      m_user_d  = ID_WIDTH'(grant_idx);
      m_fixed_d = grant_fixed;
      rr_d      = (grant_idx == PTR_W'(NUM - 1)) ? '0 : grant_idx + 1'b1;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // Issue-side state register; cke low freezes everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_q      <= '0;
      credit_q  <= '0;
      m_valid_q <= 1'b0;
      m_user_q  <= '0;
      m_fixed_q <= '0;
    end else if (cke) begin
      rr_q      <= rr_d;
      credit_q  <= credit_d;
      m_valid_q <= m_valid_d;
      m_user_q  <= m_user_d;
      m_fixed_q <= m_fixed_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_user  = m_user_q;
  assign m_fixed = m_fixed_q;

  generate
    for (genvar gi = 0; gi < NUM; gi++) begin : g_ret
      logic                     rsp_valid_q, rsp_valid_d;
      logic [M_FIXED_WIDTH-1:0] rsp_fixed_q, rsp_fixed_d;

      // A new load wins over a drain so back-to-back results stream at full rate.
      always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_fixed_d = rsp_fixed_q;
        if (ret_load[gi]) begin
          rsp_valid_d = 1'b1;
          rsp_fixed_d = s_fixed;
        end else if (m_rsp_ready[gi]) begin
          rsp_valid_d = 1'b0;
        end
      end

      // Per-port response slot register.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          rsp_valid_q <= 1'b0;
          rsp_fixed_q <= '0;
        end else if (cke) begin
          rsp_valid_q <= rsp_valid_d;
          rsp_fixed_q <= rsp_fixed_d;
        end
      end

      assign m_rsp_valid[gi]                                  = rsp_valid_q;
      assign m_rsp_fixed[gi*M_FIXED_WIDTH +: M_FIXED_WIDTH]   = rsp_fixed_q;
    end
  endgenerate

`ifdef JELLY_FIXED_RECIPROCAL_ARBITER_STATUS_EN
  logic [NUM-1:0] status_grant_q, status_grant_d;

  assign status_grant_d = s_req_ready;

  // Registered copy of this cycle's one-hot grant for observation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_grant_q <= '0;
    end else if (cke) begin
      status_grant_q <= status_grant_d;
    end
  end

  assign status_credit = credit_q;
  assign status_grant  = status_grant_q;
`endif

endmodule

// File: tb/tb_jelly_fixed_reciprocal_arbiter.sv
// Testbench for jelly_fixed_reciprocal_arbiter: a 3-stage stub reciprocal
// pipeline in Q16.16, random AXI-stream requesters/consumers, and a
// reference model of round-robin grant order, credit and per-port results.
`timescale 1ns/1ps
module tb_jelly_fixed_reciprocal_arbiter;

  localparam int NUM  = 4;
  localparam int IDW  = 2;
  localparam int SW   = 32;
  localparam int MW   = 32;
  localparam int MAXO = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              cke;
  logic [NUM*SW-1:0] s_req_fixed;
  logic [NUM-1:0]    s_req_valid;
  logic [NUM-1:0]    s_req_ready;
  logic [NUM*MW-1:0] m_rsp_fixed;
  logic [NUM-1:0]    m_rsp_valid;
  logic [NUM-1:0]    m_rsp_ready;
  logic [IDW-1:0]    m_user;
  logic [SW-1:0]     m_fixed;
  logic              m_valid;
  logic              m_ready;
  logic [IDW-1:0]    s_user;
  logic [MW-1:0]     s_fixed;
  logic              s_valid;
  logic              s_ready;
`ifdef JELLY_FIXED_RECIPROCAL_ARBITER_STATUS_EN
  logic [7:0]        status_credit;
  logic [NUM-1:0]    status_grant;
`endif

  always #5 clk = ~clk;

  jelly_fixed_reciprocal_arbiter #(
    .NUM(NUM), .ID_WIDTH(IDW), .S_FIXED_WIDTH(SW), .M_FIXED_WIDTH(MW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cke(cke),
    .s_req_fixed(s_req_fixed), .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .m_rsp_fixed(m_rsp_fixed), .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready),
    .m_user(m_user), .m_fixed(m_fixed), .m_valid(m_valid), .m_ready(m_ready),
    .s_user(s_user), .s_fixed(s_fixed), .s_valid(s_valid), .s_ready(s_ready)
`ifdef JELLY_FIXED_RECIPROCAL_ARBITER_STATUS_EN
    , .status_credit(status_credit), .status_grant(status_grant)
`endif
  );

  // Q16.16 reciprocal: 1.0 / x = 2^32 / x (truncating toward zero)
  function automatic logic [MW-1:0] recip(input logic [SW-1:0] x);
    longint den;
    longint q;
    if (x == '0) return 32'h7fff_ffff;
    den = longint'($signed(x));
    q   = (64'sd1 <<< 32) / den;
    return q[31:0];
  endfunction

  // ---------------- stub 3-stage pipeline (global stall) ----------------
  logic           pipe_en;
  logic [2:0]     p_v;
  logic [IDW-1:0] p_u [3];
  logic [MW-1:0]  p_d [3];
  logic           pipe_adv;

  assign pipe_adv = cke & (~p_v[2] | s_ready);
  assign m_ready  = pipe_adv & pipe_en;
  assign s_valid  = p_v[2];
  assign s_user   = p_u[2];
  assign s_fixed  = p_d[2];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_v <= '0;
      for (int k = 0; k < 3; k++) begin
        p_u[k] <= '0;
        p_d[k] <= '0;
      end
    end else if (pipe_adv) begin
      p_v    <= {p_v[1:0], m_valid & m_ready};
      p_u[2] <= p_u[1];
      p_u[1] <= p_u[0];
      p_u[0] <= m_user;
      p_d[2] <= p_d[1];
      p_d[1] <= p_d[0];
      p_d[0] <= recip(m_fixed);
    end
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [MW-1:0] exp_q [NUM][$];
  int            mdl_rr;
  int            mdl_credit;
  int            n_issued;
  int            n_returned;

  // stimulus knobs
  logic [NUM-1:0] req_auto;
  int             req_pct;
  logic [NUM-1:0] rsp_block;
  bit             rsp_rand;
  bit             pipe_toggle;
  logic           cke_next;
  bit             inj_valid;
  int             inj_port;
  logic [SW-1:0]  inj_val;

  // last-sample history
  logic [NUM-1:0] req_taken;
  bit             last_grant;
  int             last_port;
  logic [SW-1:0]  last_fixed;
  bit             last_hold;
  logic [IDW-1:0] hold_user;
  logic [SW-1:0]  hold_fixed;
  bit             rsp_pending;
  int             rsp_pending_port;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SW-1:0] rand_operand();
    logic [SW-1:0] mag;
    mag = SW'($urandom_range(32'h7fff_0000, 32'h0002_0000));
    return ($urandom_range(1) == 1) ? (~mag + 1'b1) : mag;
  endfunction

  function automatic int outstanding();
    int s;
    s = mdl_credit + $countones(s_req_valid);
    for (int i = 0; i < NUM; i++) s += exp_q[i].size();
    return s;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NUM; i++) exp_q[i].delete();
    mdl_rr = 0; mdl_credit = 0; n_issued = 0; n_returned = 0;
    req_taken = '0; last_grant = 0; last_hold = 0; rsp_pending = 0;
    s_req_valid = '0;
  endtask

  // Registered-output checks made at the falling edge.
  task automatic check_registered();
    if (last_grant) begin
      chk("issue_valid", m_valid, 1);
      chk("issue_user", m_user, 64'(last_port));
      chk("issue_fixed", m_fixed, last_fixed);
    end else if (last_hold) begin
      chk("hold_valid", m_valid, 1);
      chk("hold_user", m_user, hold_user);
      chk("hold_fixed", m_fixed, hold_fixed);
    end
    if (rsp_pending) chk("rsp_latency", m_rsp_valid[rsp_pending_port], 1);
  endtask

  task automatic drive_inputs();
    cke = cke_next;
    for (int i = 0; i < NUM; i++) begin
      if (req_taken[i]) s_req_valid[i] = 1'b0;
      if (!s_req_valid[i] && req_auto[i] && ($urandom_range(99) < req_pct)) begin
        s_req_valid[i]          = 1'b1;
        s_req_fixed[i*SW +: SW] = rand_operand();
      end
      m_rsp_ready[i] = rsp_block[i] ? 1'b0 : (rsp_rand ? ($urandom_range(3) != 0) : 1'b1);
    end
    if (inj_valid) begin
      s_req_valid[inj_port]          = 1'b1;
      s_req_fixed[inj_port*SW +: SW] = inj_val;
      inj_valid                      = 0;
    end
    pipe_en = pipe_toggle ? ~pipe_en : 1'b1;
  endtask

  // Combinational checks and model update just after inputs settle.
  task automatic sample_cycle();
    logic [NUM-1:0] exp_ready;
    logic           exp_sready;
    bit             found;
    int             p;
    exp_ready = '0;
    found     = 0;
    if (cke && reset_n && (!m_valid || m_ready) && (mdl_credit < MAXO)) begin
      for (int k = 0; k < NUM; k++) begin
        p = (mdl_rr + k) % NUM;
        if (!found && s_req_valid[p]) begin
          found        = 1;
          exp_ready[p] = 1'b1;
        end
      end
    end
    chk("s_req_ready", s_req_ready, exp_ready);
    exp_sready = cke && reset_n && !(m_rsp_valid[s_user] && !m_rsp_ready[s_user]);
    chk("s_ready", s_ready, exp_sready);

    req_taken  = s_req_valid & s_req_ready & {NUM{cke}};
    last_grant = 0;
    for (int i = 0; i < NUM; i++) begin
      if (req_taken[i]) begin
        exp_q[i].push_back(recip(s_req_fixed[i*SW +: SW]));
        mdl_rr     = (i + 1) % NUM;
        mdl_credit++;
        n_issued++;
        last_grant = 1;
        last_port  = i;
        last_fixed = s_req_fixed[i*SW +: SW];
      end
    end
    rsp_pending = 0;
    if (cke && s_valid && s_ready) begin
      mdl_credit--;
      rsp_pending      = 1;
      rsp_pending_port = int'(s_user);
    end
    for (int i = 0; i < NUM; i++) begin
      if (cke && m_rsp_valid[i] && m_rsp_ready[i]) begin
        if (exp_q[i].size() == 0) begin
          chk($sformatf("rsp%0d_spurious", i), 64'(m_rsp_valid[i]), 0);
        end else begin
          chk($sformatf("rsp%0d_data", i), m_rsp_fixed[i*MW +: MW], exp_q[i].pop_front());
          n_returned++;
        end
      end
    end
    last_hold  = m_valid && !m_ready;
    hold_user  = m_user;
    hold_fixed = m_fixed;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_registered();
    drive_inputs();
    #1;
    sample_cycle();
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_m_valid"}, m_valid, 0);
    chk({pfx, "_m_user"}, m_user, 0);
    chk({pfx, "_m_fixed"}, m_fixed, 0);
    chk({pfx, "_rsp_valid"}, m_rsp_valid, 0);
    chk({pfx, "_rsp_fixed"}, m_rsp_fixed, 0);
    chk({pfx, "_req_ready"}, s_req_ready, 0);
    chk({pfx, "_s_ready"}, s_ready, 0);
  endtask

  task automatic drain(input string tag, input int budget);
    int k;
    k = 0;
    while (outstanding() != 0 && k < budget) begin
      cycle();
      k++;
    end
    chk(tag, 64'(outstanding()), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, finish required");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    logic           snap_valid;
    logic [IDW-1:0] snap_user;
    logic [SW-1:0]  snap_fixed;
    logic [NUM-1:0] snap_rsp_valid;
    logic [NUM*MW-1:0] snap_rsp_fixed;

    reset_n = 1'b0; cke = 1'b1; cke_next = 1'b1;
    s_req_valid = '0; s_req_fixed = '0; m_rsp_ready = '1; pipe_en = 1'b1;
    req_auto = '0; req_pct = 100; rsp_block = '0; rsp_rand = 0; pipe_toggle = 0;
    inj_valid = 0; inj_port = 0; inj_val = '0;
    clear_model();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // Single port: 2.0 -> 0.5
    inj_valid = 1; inj_port = 0; inj_val = 32'h0002_0000;
    k = 0;
    while (!m_rsp_valid[0] && k < 20) begin cycle(); k++; end
    chk("t1_rsp_valid", m_rsp_valid[0], 1);
    chk("t1_rsp_fixed", m_rsp_fixed[31:0], 32'h0000_8000);
    chk("t1_latency", 64'(k), 6);
    chk("t1_others", m_rsp_valid[3:1], 0);

    // All ports continuously valid, pipeline ready
    req_auto = '1; req_pct = 100;
    repeat (40) cycle();

    // Port 2 consumer blocked: credit fills, issue stops
    rsp_block = 4'b0100;
    repeat (30) cycle();
    chk("t3_req_pending", 64'(s_req_valid != 0), 1);
    chk("t3_req_blocked", s_req_ready, 0);
    chk("t3_credit_bound", 64'(mdl_credit <= MAXO), 1);
    rsp_block = '0;
    k = 0;
    while (s_req_ready == '0 && k < 20) begin cycle(); k++; end
    chk("t3_resume", 64'(s_req_ready != 0), 1);
    repeat (10) cycle();

    // Pipeline ready toggling with random consumers
    pipe_toggle = 1; rsp_rand = 1; req_pct = 70;
    repeat (40) cycle();

    // Reset with operations in flight
    k = 0;
    while (mdl_credit < 3 && k < 20) begin cycle(); k++; end
    req_auto = '0; pipe_toggle = 0; rsp_rand = 0;
    @(negedge clk);
    check_registered();
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    clear_model();
    cycle();
    check_reset_outputs("midreset_clk");
    reset_n = 1'b1;
    inj_valid = 1; inj_port = 1; inj_val = 32'h0004_0000;
    k = 0;
    while (!m_rsp_valid[1] && k < 20) begin cycle(); k++; end
    chk("t5_rsp_valid", m_rsp_valid[1], 1);
    chk("t5_rsp_fixed", m_rsp_fixed[63:32], 32'h0000_4000);

    // Clock-enable stall mid-stream
    req_auto = '1; req_pct = 70; rsp_rand = 1;
    repeat (15) cycle();
    cke_next = 1'b0;
    cycle();
    snap_valid = m_valid; snap_user = m_user; snap_fixed = m_fixed;
    snap_rsp_valid = m_rsp_valid; snap_rsp_fixed = m_rsp_fixed;
    repeat (4) begin
      cycle();
      chk("t6_req_ready", s_req_ready, 0);
      chk("t6_s_ready", s_ready, 0);
      chk("t6_m_valid", m_valid, snap_valid);
      chk("t6_m_user", m_user, snap_user);
      chk("t6_m_fixed", m_fixed, snap_fixed);
      chk("t6_rsp_valid", m_rsp_valid, snap_rsp_valid);
      chk("t6_rsp_fixed_lo", m_rsp_fixed[63:0], snap_rsp_fixed[63:0]);
      chk("t6_rsp_fixed_hi", m_rsp_fixed[127:64], snap_rsp_fixed[127:64]);
    end
    cke_next = 1'b1;
    repeat (30) cycle();

    // Drain everything and reconcile counts
    req_auto = '0; rsp_rand = 0; rsp_block = '0;
    drain("final_drain", 200);
    chk("final_count", 64'(n_returned), 64'(n_issued));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/jelly_fixed_reciprocal_arbiter.md
Name: jelly_fixed_reciprocal_arbiter

Overview:
- Shares one fixed-point reciprocal pipeline (valid/ready, user-tagged) between NUM requesters.
- Round-robin arbitration of request ports into the pipeline's slave side; requester index carried in the user field.
- Results returned on the pipeline's master side are routed back to the matching requester's response port.
- An outstanding-credit counter bounds in-flight operations, so a stalled response port can never deadlock the shared pipeline.

Parameters:
- NUM, 4, number of requesters (2..16).
- ID_WIDTH, 2, tag width; must be >= clog2(NUM).
- S_FIXED_WIDTH, 32, request operand width (signed).
- M_FIXED_WIDTH, 32, result width (signed).
- MAX_OUTSTANDING, 16, maximum in-flight operations (1..255); must be >= pipeline depth for full throughput.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- cke  in  1  clock enable; all state holds while low.
- s_req_fixed  in  NUM*S_FIXED_WIDTH  requester operands, port i at [i*S_FIXED_WIDTH +: S_FIXED_WIDTH].
- s_req_valid  in  NUM  request valid.
- s_req_ready  out  NUM  request accepted.
- m_rsp_fixed  out  NUM*M_FIXED_WIDTH  per-port reciprocal result.
- m_rsp_valid  out  NUM  result valid.
- m_rsp_ready  in  NUM  result accepted.
- m_user  out  ID_WIDTH  tag to pipeline.
- m_fixed  out  S_FIXED_WIDTH  operand to pipeline.
- m_valid  out  1  issue valid.
- m_ready  in  1  pipeline ready.
- s_user  in  ID_WIDTH  returned tag.
- s_fixed  in  M_FIXED_WIDTH  returned result.
- s_valid  in  1  return valid.
- s_ready  out  1  return accepted.

Behaviour:
- Reset: m_valid=0, m_user=0, m_fixed=0, m_rsp_valid=0, m_rsp_fixed=0, credit=0, rr pointer=0. s_req_ready=0 and s_ready=0 while reset_n is low.
- Issue stage:
  - Output register holds m_user, m_fixed and m_valid.
  - The register is free when !m_valid or m_ready.
  - When the register is free and credit<MAX_OUTSTANDING, grant the first valid port at or after the rr pointer (wrapping). Only that port sees s_req_ready=1 (combinational).
  - On grant: load the register, set m_valid, set rr pointer = granted+1 mod NUM, credit += 1.
  - Latency from request acceptance to m_valid is 1 cycle.
  - Sustained throughput is 1 operation per cycle.
- Credit:
  - Increments on a request grant; decrements on a response acceptance (s_valid & s_ready).
  - A simultaneous grant and response leaves credit unchanged.
  - When credit==MAX_OUTSTANDING, all s_req_ready=0 (a response in the same cycle does not bypass this).
  - Credit never exceeds MAX_OUTSTANDING and never underflows.
- Return stage:
  - Per-port one-deep register holding m_rsp_fixed and m_rsp_valid.
  - s_ready = !m_rsp_valid[s_user] | m_rsp_ready[s_user].
  - On acceptance, load port s_user and set its valid. Clear valid on m_rsp_ready when no new load.
  - Latency from return to m_rsp_valid is 1 cycle.
  - A blocked port back-pressures the whole pipeline. Credit limits the depth of this stall.
- s_user >= NUM is a protocol error: the return is accepted and dropped, and credit is still decremented.
- AXI-stream rules apply to all ports:
  - Asserted valid holds until accepted.
  - Data is stable while valid and not ready.
  - Ready may depend on valid.
- cke=0 freezes every register; all ready outputs are 0.
- Reset mid-operation discards in-flight tags. The pipeline must be reset together with this block.

Optional Feature:
- Macro: JELLY_FIXED_RECIPROCAL_ARBITER_STATUS_EN.
- Defined: adds outputs status_credit [8] (current credit count) and status_grant [NUM] (one-hot grant of the current cycle, registered, reset 0).
- Undefined: these ports and their registers are absent. All other behaviour is identical.

Test Plan:
- Single port: port 0 sends 0x0002_0000 (2.0 in Q16.16) with a stubbed 3-cycle pipeline returning the tag -> m_rsp_valid[0] asserts with 0x0000_8000; no other port valid.
- All 4 ports valid continuously, pipeline ready -> grants in order 0,1,2,3,0,…; each port receives exactly its own results, and the result count equals the issue count.
- Port 2 holds m_rsp_ready=0, MAX_OUTSTANDING=4 -> after 4 grants all s_req_ready=0, credit=4, no result lost; releasing port 2 drains it and issue resumes.
- Pipeline m_ready toggling 1/0 while requests are valid -> m_fixed and m_user stay stable while m_valid & !m_ready; no duplicate or skipped grants.
- reset_n pulled low with 3 operations in flight -> next cycle every output is at its reset value and credit=0; after release, the port 1 request 0x0004_0000 returns 0x0000_4000.
- cke=0 for 5 cycles mid-stream -> all state frozen, all ready outputs 0; resuming gives results identical to a run without the stall.
